matmul_arbiter: RTL and testbench

Round-robin scheduler that shares one `sequential_matrix_multiply` instance (4x4, Q-format fixed point) among up to NREQ requesters, such as the covariance, gain and update stages of the Kalman filter.

- Latches the granted requester's operands and drives the multiplier's active-low reset.
- Counts the fixed multiply latency, captures the result and returns it with a one-cycle per-requester done strobe.
- Sits between the filter's stage controllers and the single multiplier.

---
 rtl/matmul_arbiter_if.sv | 46 ++++
 rtl/matmul_arbiter.sv | 169 ++++++++++++++++
 tb/tb_matmul_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_arbiter_if.sv
// Bus bundle between the Kalman stage controllers, the shared 4x4 multiplier
// and the matmul arbiter. The arbiter side uses the slave modport.
interface matmul_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*16*N-1:0] a_in;
    logic [NREQ*16*N-1:0] b_in;
    logic [16*N-1:0]      smm_a;
    logic [16*N-1:0]      smm_b;
    logic                 smm_rst_n;
    logic [16*N-1:0]      smm_result;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [16*N-1:0]      result;
    logic                 busy;

    modport slave (
        input  req,
        input  a_in,
        input  b_in,
        input  smm_result,
        output smm_a,
        output smm_b,
        output smm_rst_n,
        output grant,
        output done,
        output result,
        output busy
    );

    modport master (
        output req,
        output a_in,
        output b_in,
        output smm_result,
        input  smm_a,
        input  smm_b,
        input  smm_rst_n,
        input  grant,
        input  done,
        input  result,
        input  busy
    );
endinterface

// File: rtl/matmul_arbiter.sv
// Round-robin scheduler sharing one sequential 4x4 fixed-point multiplier among
// NREQ requesters; latches operands, times the multiply and returns the product.
module matmul_arbiter #(
    parameter int N    = 32,
    parameter int Q    = 18,
    parameter int NREQ = 4,
    parameter int LAT  = 18
) (
    input  logic            clk,
    input  logic            reset,
    matmul_arbiter_if.slave bus
);
    localparam int MW = 16 * N;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 1);

    // Q only describes the multiplier's number format; it is range-checked here.
    if ((NREQ < 2) || (NREQ > 8) || (LAT < 1) || (Q < 0) || (Q >= N)) begin : g_bad_params
        $error("matmul_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   r_sel;
    logic [PW-1:0]   w_sel_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_grant_nxt;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] w_done_nxt;
    logic [MW-1:0]   r_result;
    logic [MW-1:0]   w_result_nxt;
    logic [MW-1:0]   r_smm_a;
    logic [MW-1:0]   w_smm_a_nxt;
    logic [MW-1:0]   r_smm_b;
    logic [MW-1:0]   w_smm_b_nxt;
    logic            r_smm_rst_n;
    logic            w_smm_rst_n_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    logic [PW:0]     w_raw;
    logic [PW-1:0]   w_idx;
    logic            w_hit;
    logic            w_found;
    logic [PW-1:0]   w_winner;

    logic [MW-1:0]   w_a_slice [NREQ];
    logic [MW-1:0]   w_b_slice [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign w_a_slice[k] = bus.a_in[k*MW +: MW];
        assign w_b_slice[k] = bus.b_in[k*MW +: MW];
    end

    // Round-robin search: first asserted request at or above ptr, wrapping around
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_raw    = '0;
        w_idx    = '0;
        w_hit    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_raw    = {1'b0, r_ptr} + (PW+1)'(i);
            w_idx    = (w_raw >= (PW+1)'(NREQ)) ? PW'(w_raw - (PW+1)'(NREQ)) : w_raw[PW-1:0];
            w_hit    = !w_found && bus.req[w_idx];
            w_winner = w_hit ? w_idx : w_winner;
            w_found  = w_found | w_hit;
        end
    end

    // Next-state and next-register values for the IDLE/RUN/DONE sequence
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_sel_nxt       = r_sel;
        w_grant_nxt     = r_grant;
        w_done_nxt      = '0;
        w_result_nxt    = r_result;
        w_smm_a_nxt     = r_smm_a;
        w_smm_b_nxt     = r_smm_b;
        w_smm_rst_n_nxt = r_smm_rst_n;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt     = NREQ'(1'b1) << w_winner;
                    w_sel_nxt       = w_winner;
                    w_smm_a_nxt     = w_a_slice[w_winner];
                    w_smm_b_nxt     = w_b_slice[w_winner];
                    w_smm_rst_n_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_RUN;
                end else begin
                    w_grant_nxt     = '0;
                    w_smm_rst_n_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (r_cnt == CW'(LAT)) begin
                    w_result_nxt    = bus.smm_result;
                    w_smm_rst_n_nxt = 1'b0;
                    w_done_nxt      = r_grant;
                    w_state_nxt     = ST_DONE;
                end else begin
                    w_cnt_nxt       = r_cnt + CW'(1'b1);
                end
            end
            ST_DONE: begin
                // The requester just served drops to lowest priority.
                w_ptr_nxt   = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + PW'(1'b1);
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt     = '0;
                w_smm_rst_n_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; an asynchronous reset discards any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_smm_a     <= '0;
            r_smm_b     <= '0;
            r_smm_rst_n <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_result    <= w_result_nxt;
            r_smm_a     <= w_smm_a_nxt;
            r_smm_b     <= w_smm_b_nxt;
            r_smm_rst_n <= w_smm_rst_n_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.busy      = r_busy;
    assign bus.smm_a     = r_smm_a;
    assign bus.smm_b     = r_smm_b;
    assign bus.smm_rst_n = r_smm_rst_n;
endmodule

// File: tb/tb_matmul_arbiter.sv
// Bench for matmul_arbiter: behavioural multiplier plus requesters, with a
// scoreboard of expected results in the predicted service order.
module tb_matmul_arbiter;
    localparam int N    = 32;
    localparam int Q    = 18;
    localparam int NREQ = 4;
    localparam int LAT  = 18;
    localparam int MW   = 16 * N;
    localparam logic [MW-1:0] JUNK = {16{32'hDEAD_BEEF}};

    typedef struct {
        int            id;
        logic [MW-1:0] exp;
        int            cyc;
    } sb_t;

    logic clk;
    logic reset;
    matmul_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    matmul_arbiter #(.N(N), .Q(Q), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sb_t             sb[$];
    int              n_chk  = 0;
    int              n_pass = 0;
    int              cyc    = 0;
    int              hi_cnt = 0;
    int              last_hi = 0;
    int              mcnt   = 0;
    bit              auto_drop = 1'b1;
    logic [NREQ-1:0] prev_grant = '0;
    logic [MW-1:0]   ra [NREQ];
    logic [MW-1:0]   rb [NREQ];

    function automatic logic [MW-1:0] mm(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0]         r;
        longint                acc;
        logic signed [N-1:0]   ea;
        logic signed [N-1:0]   eb;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 64'sd0;
                for (int k = 0; k < 4; k++) begin
                    ea  = a[(i*4+k)*N +: N];
                    eb  = b[(k*4+j)*N +: N];
                    acc = acc + longint'(ea) * longint'(eb);
                end
                r[(i*4+j)*N +: N] = N'(acc >>> Q);
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] diag(input logic [N-1:0] v);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[(i*5)*N +: N] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < 16; i++) m[i*N +: N] = $urandom();
        return m;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int id);
        return NREQ'(1'b1) << id;
    endfunction

    // Behavioural multiplier: product is only valid exactly LAT cycles after release
    always @(posedge clk) mcnt <= bus.smm_rst_n ? mcnt + 1 : 0;
    assign bus.smm_result = (bus.smm_rst_n && (mcnt == LAT)) ? mm(bus.smm_a, bus.smm_b) : JUNK;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic issue(input int id, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic [MW-1:0] exp, input int done_cyc);
        sb_t e;
        bus.a_in[id*MW +: MW] = a;
        bus.b_in[id*MW +: MW] = b;
        bus.req[id]           = 1'b1;
        e.id  = id;
        e.exp = exp;
        e.cyc = done_cyc;
        sb.push_back(e);
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.smm_rst_n) hi_cnt++;
        else begin
            last_hi = hi_cnt;
            hi_cnt  = 0;
        end
        if ((bus.grant != '0) && (prev_grant == '0)) begin
            if (sb.size() == 0) check_eq("grant_unexpected", MW'(bus.grant), MW'(0));
            else begin
                check_eq("grant_id", MW'(bus.grant), MW'(oh(sb[0].id)));
                check_eq("grant_cyc", MW'(cyc), MW'(sb[0].cyc - (LAT + 1)));
                check_eq("busy_run", MW'(bus.busy), MW'(1));
            end
        end
        if (bus.done != '0) begin
            if (sb.size() == 0) check_eq("done_unexpected", MW'(bus.done), MW'(0));
            else begin
                e = sb.pop_front();
                check_eq("done_id", MW'(bus.done), MW'(oh(e.id)));
                check_eq("done_cyc", MW'(cyc), MW'(e.cyc));
                check_eq("result", bus.result, e.exp);
                check_eq("grant_hold", MW'(bus.grant), MW'(oh(e.id)));
                check_eq("rst_n_high_len", MW'(last_hi), MW'(LAT + 1));
                check_eq("busy_done", MW'(bus.busy), MW'(1));
                if (auto_drop) bus.req = bus.req & ~bus.done;
                if (sb.size() == 0) bus.req = '0;
            end
        end
        prev_grant = bus.grant;
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; (k < budget) && (sb.size() != 0); k++) step();
        if (sb.size() != 0) begin
            check_eq("timeout", MW'(sb.size()), MW'(0));
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_grant"},     MW'(bus.grant),     MW'(0));
        check_eq({tag, "_done"},      MW'(bus.done),      MW'(0));
        check_eq({tag, "_result"},    bus.result,         MW'(0));
        check_eq({tag, "_busy"},      MW'(bus.busy),      MW'(0));
        check_eq({tag, "_smm_rst_n"}, MW'(bus.smm_rst_n), MW'(0));
        check_eq({tag, "_smm_a"},     bus.smm_a,          MW'(0));
        check_eq({tag, "_smm_b"},     bus.smm_b,          MW'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int id;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        clk      = 1'b0;
        reset    = 1'b0;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) step();
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (2) step();

        // All four request together: served 0,1,2,3, one period apart
        c0 = cyc;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = rnd_mat();
            rb[i] = rnd_mat();
            issue(i, ra[i], rb[i], mm(ra[i], rb[i]), c0 + LAT + 2 + (LAT + 3) * i);
        end
        wait_empty(4 * (LAT + 3) + 20);
        repeat (2) step();

        // Requesters 0 and 2 held continuously: grants alternate
        auto_drop = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            id = (i % 2) * 2;
            issue(id, ra[id], rb[id], mm(ra[id], rb[id]), c0 + LAT + 2 + (LAT + 3) * i);
        end
        wait_empty(4 * (LAT + 3) + 20);
        auto_drop = 1'b1;
        repeat (2) step();

        // Single request: identity times diag(2.0)
        c0 = cyc;
        issue(0, diag(32'h0004_0000), diag(32'h0008_0000), diag(32'h0008_0000), c0 + LAT + 2);
        wait_empty(LAT + 20);
        repeat (2) step();

        // Operand change during RUN is ignored
        c0 = cyc;
        a = rnd_mat();
        b = rnd_mat();
        issue(0, a, b, mm(a, b), c0 + LAT + 2);
        repeat (5) step();
        bus.a_in[0 +: MW] = '0;
        wait_empty(LAT + 20);
        repeat (2) step();

        // req dropped mid-RUN still completes
        c0 = cyc;
        a = rnd_mat();
        b = rnd_mat();
        issue(1, a, b, mm(a, b), c0 + LAT + 2);
        repeat (3) step();
        bus.req[1] = 1'b0;
        wait_empty(LAT + 20);
        repeat (2) step();

        // Reset mid-RUN: aborted op never completes, ptr restarts at 0
        c0 = cyc;
        a = rnd_mat();
        b = rnd_mat();
        issue(3, a, b, mm(a, b), c0 + LAT + 2);
        repeat (10) step();
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        sb.delete();
        bus.req = '0;
        repeat (2) step();
        reset = 1'b1;
        c0 = cyc;
        ra[0] = rnd_mat();
        rb[0] = rnd_mat();
        ra[2] = rnd_mat();
        rb[2] = rnd_mat();
        issue(0, ra[0], rb[0], mm(ra[0], rb[0]), c0 + LAT + 2);
        issue(2, ra[2], rb[2], mm(ra[2], rb[2]), c0 + 2 * LAT + 5);
        wait_empty(2 * (LAT + 3) + 20);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
